// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit: owns the PC, issues to a 1-cycle instr_mem, buffers 2 returns.
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int                WORD_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [WORD_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [WORD_W-1:0]  pc,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               branch_taken,
  input  logic [WORD_W-1:0]  branch_target,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [WORD_W-1:0]  if_pc
);

  localparam logic [2:0]        C_DEPTH    = 3'(DEPTH);
  localparam logic [WORD_W-1:0] C_PC_STEP  = WORD_W'(4);
  localparam logic [WORD_W-1:0] C_ALIGN    = ~WORD_W'(3);

  logic [WORD_W-1:0]  r_pc;
  logic               r_req_v;
  logic [WORD_W-1:0]  r_req_pc;
  logic [1:0]         r_count;
  logic [WORD_W-1:0]  r_head_pc;
  logic [INSTR_W-1:0] r_head_instr;
  logic [WORD_W-1:0]  r_tail_pc;
  logic [INSTR_W-1:0] r_tail_instr;

  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic [2:0] w_occ;
  logic       w_head_from_mem;
  logic       w_head_from_tail;
  logic       w_tail_from_mem;

  // Occupancy counts the in-flight word too, so a full buffer never overflows.
  always_comb begin
    w_pop            = (r_count != 2'd0) & if_ready;
    w_push           = r_req_v & ~branch_taken;
    w_occ            = {1'b0, r_count} + {2'b00, r_req_v} - {2'b00, w_pop};
    w_issue          = fetch_en & ~branch_taken & (w_occ < C_DEPTH);
    w_head_from_mem  = w_push & ((r_count == 2'd0) | ((r_count == 2'd1) & w_pop));
    w_head_from_tail = w_pop & (r_count == 2'd2);
    w_tail_from_mem  = w_push & (((r_count == 2'd1) & ~w_pop) |
                                 ((r_count == 2'd2) & w_pop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_req_v      <= 1'b0;
      r_req_pc     <= '0;
      r_count      <= 2'd0;
      r_head_pc    <= '0;
      r_head_instr <= '0;
      r_tail_pc    <= '0;
      r_tail_instr <= '0;
    end else if (branch_taken) begin
      r_pc    <= branch_target & C_ALIGN;
      r_req_v <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_issue) begin
        r_req_v  <= 1'b1;
        r_req_pc <= r_pc;
        r_pc     <= r_pc + C_PC_STEP;
      end else begin
        r_req_v  <= 1'b0;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_head_from_mem) begin
        r_head_pc    <= r_req_pc;
        r_head_instr <= mem_instr;
      end else if (w_head_from_tail) begin
        r_head_pc    <= r_tail_pc;
        r_head_instr <= r_tail_instr;
      end
      if (w_tail_from_mem) begin
        r_tail_pc    <= r_req_pc;
        r_tail_instr <= mem_instr;
      end
    end
  end

  assign pc       = r_pc;
  assign if_valid = (r_count != 2'd0);
  assign if_pc    = r_head_pc;
  assign if_instr = r_head_instr;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit: scoreboard bench for fetch_unit with a 64-word instr_mem model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        if_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] mem_instr = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic [31:0] mem [64];
  logic [63:0] exp_q [$];
  logic [63:0] exp_e;
  logic [63:0] got;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.WORD_W(32), .INSTR_W(32), .RESET_PC(32'd0), .DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en     (fetch_en),
    .pc           (pc),
    .mem_instr    (mem_instr),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc)
  );

  assign got = {if_pc, if_instr};

  // Standard image: word k is 8 hex digits from the cycle "ABCDEF123456789" starting at k mod 15.
  function automatic logic [31:0] img(int k);
    logic [31:0] w;
    int d;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      d = (k + j) % 15;
      w = {w[27:0], (d < 6) ? 4'(10 + d) : 4'(d - 5)};
    end
    return w;
  endfunction

  function automatic logic [63:0] ent(logic [31:0] a);
    return {a, img(int'(a[7:2]))};
  endfunction

  initial for (int k = 0; k < 64; k++) mem[k] = img(k);

  always @(posedge clk) mem_instr <= mem[pc[7:2]];

  always @(negedge clk) begin
    if (rst_n && dut.r_count > 2'd2) begin
      n_checks++;
      $display("FAIL count_bound: got %0d want <=2", dut.r_count);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; fetch_en = 1'b0; branch_taken = 1'b0; if_ready = 1'b0;
    branch_target = '0;
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", if_valid); else n_pass++;
    n_checks++; if (pc !== 32'd0) $display("FAIL rst_pc: got %h want 00000000", pc); else n_pass++;
    n_checks++; if (if_pc !== 32'd0) $display("FAIL rst_if_pc: got %h want 00000000", if_pc); else n_pass++;
    n_checks++; if (if_instr !== 32'd0) $display("FAIL rst_if_instr: got %h want 00000000", if_instr); else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    exp_q.push_back(ent(32'd0)); exp_q.push_back(ent(32'd4)); exp_q.push_back(ent(32'd8));
    tick();
    n_checks++; if (if_valid !== 1'b0) $display("FAIL basic_lat: got v=%0b want 0", if_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_e = exp_q.pop_front();
      n_checks++;
      if (if_valid !== 1'b1 || got !== exp_e)
        $display("FAIL basic_seq%0d: got v=%0b %h want v=1 %h", i, if_valid, got, exp_e);
      else n_pass++;
    end
  endtask

  task automatic test_stall;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0;
    for (int a = 0; a < 16; a += 4) exp_q.push_back(ent(32'(a)));
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (if_valid !== 1'b1 || got !== exp_q[0])
        $display("FAIL stall_hold%0d: got v=%0b %h want v=1 %h", i, if_valid, got, exp_q[0]);
      else n_pass++;
      if (i == 4) begin
        n_checks++; if (dut.r_count !== 2'd2) $display("FAIL stall_count: got %0d want 2", dut.r_count); else n_pass++;
        n_checks++; if (pc !== 32'd8) $display("FAIL stall_pc: got %h want 00000008", pc); else n_pass++;
      end
      if (i < 4) tick();
    end
    if_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_e = exp_q.pop_front();
      n_checks++;
      if (if_valid !== 1'b1 || got !== exp_e)
        $display("FAIL stall_release%0d: got v=%0b %h want v=1 %h", j, if_valid, got, exp_e);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0;
    tick(); tick();
    n_checks++; if (dut.r_count !== 2'd1 || dut.r_req_v !== 1'b1)
      $display("FAIL redir_pre: got cnt=%0d req=%0b want cnt=1 req=1", dut.r_count, dut.r_req_v); else n_pass++;
    branch_taken = 1'b1; branch_target = 32'd52;
    exp_q.push_back(ent(32'd52)); exp_q.push_back(ent(32'd56));
    tick();
    branch_taken = 1'b0; if_ready = 1'b1;
    n_checks++; if (if_valid !== 1'b0 || pc !== 32'd52)
      $display("FAIL redir_drop: got v=%0b pc=%h want v=0 pc=00000034", if_valid, pc); else n_pass++;
    tick();
    n_checks++; if (if_valid !== 1'b0) $display("FAIL redir_gap: got v=%0b want 0", if_valid); else n_pass++;
    for (int j = 0; j < 2; j++) begin
      tick();
      exp_e = exp_q.pop_front();
      n_checks++;
      if (if_valid !== 1'b1 || got !== exp_e)
        $display("FAIL redir_seq%0d: got v=%0b %h want v=1 %h", j, if_valid, got, exp_e);
      else n_pass++;
    end
  endtask

  task automatic test_misaligned;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 32'd30;
    exp_q.push_back(ent(32'd28)); exp_q.push_back(ent(32'd32));
    tick();
    branch_taken = 1'b0;
    n_checks++; if (pc !== 32'd28) $display("FAIL misal_pc: got %h want 0000001c", pc); else n_pass++;
    tick();
    for (int j = 0; j < 2; j++) begin
      tick();
      exp_e = exp_q.pop_front();
      n_checks++;
      if (if_valid !== 1'b1 || got !== exp_e)
        $display("FAIL misal_seq%0d: got v=%0b %h want v=1 %h", j, if_valid, got, exp_e);
      else n_pass++;
    end
  endtask

  task automatic test_redirect_pop;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    exp_q.push_back(ent(32'd0));
    tick(); tick();
    exp_e = exp_q.pop_front();
    n_checks++;
    if (if_valid !== 1'b1 || got !== exp_e)
      $display("FAIL rpop_head: got v=%0b %h want v=1 %h", if_valid, got, exp_e);
    else n_pass++;
    branch_taken = 1'b1; branch_target = 32'd52;
    exp_q.push_back(ent(32'd52)); exp_q.push_back(ent(32'd56)); exp_q.push_back(ent(32'd60));
    tick();
    branch_taken = 1'b0;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL rpop_drop: got v=%0b want 0", if_valid); else n_pass++;
    tick();
    n_checks++; if (if_valid !== 1'b0) $display("FAIL rpop_gap: got v=%0b want 0", if_valid); else n_pass++;
    for (int j = 0; j < 3; j++) begin
      tick();
      exp_e = exp_q.pop_front();
      n_checks++;
      if (if_valid !== 1'b1 || got !== exp_e)
        $display("FAIL rpop_seq%0d: got v=%0b %h want v=1 %h", j, if_valid, got, exp_e);
      else n_pass++;
    end
  endtask

  task automatic test_fetch_en_off;
    int cyc;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    exp_q.push_back(ent(32'd0)); exp_q.push_back(ent(32'd4));
    tick();
    fetch_en = 1'b0;
    tick();
    exp_e = exp_q.pop_front();
    n_checks++;
    if (if_valid !== 1'b1 || got !== exp_e)
      $display("FAIL fen_inflight: got v=%0b %h want v=1 %h", if_valid, got, exp_e);
    else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (if_valid !== 1'b0 || pc !== 32'd4)
        $display("FAIL fen_idle%0d: got v=%0b pc=%h want v=0 pc=00000004", i, if_valid, pc);
      else n_pass++;
      tick();
    end
    fetch_en = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!if_valid && cyc < 6);
    exp_e = exp_q.pop_front();
    n_checks++;
    if (if_valid !== 1'b1 || got !== exp_e || cyc != 2)
      $display("FAIL fen_resume: got v=%0b %h after %0d cyc want v=1 %h after 2", if_valid, got, cyc, exp_e);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    tick(); tick(); tick(); tick();
    n_checks++; if (if_valid !== 1'b1) $display("FAIL rmid_pre: got v=%0b want 1", if_valid); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0 || pc !== 32'd0)
      $display("FAIL rmid_clear: got v=%0b pc=%h want v=0 pc=00000000", if_valid, pc); else n_pass++;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(ent(32'd0)); exp_q.push_back(ent(32'd4));
    tick();
    for (int j = 0; j < 2; j++) begin
      tick();
      exp_e = exp_q.pop_front();
      n_checks++;
      if (if_valid !== 1'b1 || got !== exp_e)
        $display("FAIL rmid_seq%0d: got v=%0b %h want v=1 %h", j, if_valid, got, exp_e);
      else n_pass++;
    end
  endtask

  task automatic test_wrap;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
    exp_q.push_back(ent(32'hFFFF_FFFC)); exp_q.push_back(ent(32'd0)); exp_q.push_back(ent(32'd4));
    tick();
    branch_taken = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      tick();
      exp_e = exp_q.pop_front();
      n_checks++;
      if (if_valid !== 1'b1 || got !== exp_e)
        $display("FAIL wrap_seq%0d: got v=%0b %h want v=1 %h", j, if_valid, got, exp_e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    branch_taken = 1'b1; branch_target = 32'd52;
    tick();
    branch_target = 32'd8;
    tick();
    branch_taken = 1'b0;
    exp_q.push_back(ent(32'd8)); exp_q.push_back(ent(32'd12));
    tick();
    n_checks++; if (if_valid !== 1'b0) $display("FAIL b2b_gap: got v=%0b want 0", if_valid); else n_pass++;
    for (int j = 0; j < 2; j++) begin
      tick();
      exp_e = exp_q.pop_front();
      n_checks++;
      if (if_valid !== 1'b1 || got !== exp_e)
        $display("FAIL b2b_seq%0d: got v=%0b %h want v=1 %h", j, if_valid, got, exp_e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_misaligned();
    test_redirect_pop();
    test_fetch_en_off();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
